y_capture: RTL and testbench

// Downstream monitor stage for the 4-bit counter output y (+1 every 2 clk).

---
 rtl/y_capture_if.sv | 27 ++
 rtl/y_capture.sv | 135 +++++++++++++
 tb/tb_y_capture.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/y_capture_if.sv
// y_capture_if: record output handshake of the y_capture monitor.
//   out_valid    : head record valid (FIFO non-empty)
//   out_ready    : consumer accepts head this cycle
//   out_data     : head record new value
//   out_ts       : head record timestamp of the change
//   out_step_err : head record delta was not +1
// master = producer (y_capture), slave = consumer.
interface y_capture_if #(
  parameter int DATA_W = 4,
  parameter int TS_W   = 8
);
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [TS_W-1:0]   out_ts;
  logic              out_step_err;

  modport master (
    output out_valid, out_data, out_ts, out_step_err,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_data, out_ts, out_step_err,
    output out_ready
  );
endinterface

// File: rtl/y_capture.sv
// y_capture: monitor for the upstream counter value. Every change on din is
// tagged with a free-running timestamp and a step-error flag (delta != +1
// modulo 2^DATA_W) and queued in a first-word-fall-through FIFO.
// Ports:
//   clk      : rising-edge clock
//   rst_n    : asynchronous active-low reset, flushes all records
//   din      : monitored value
//   rec      : record output handshake (y_capture_if master)
//   overflow : sticky, a record was dropped because the FIFO was full
//   level    : FIFO occupancy 0..DEPTH
module y_capture #(
  parameter int DATA_W = 4,
  parameter int TS_W   = 8,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [DATA_W-1:0]        din,
  y_capture_if.master              rec,
  output logic                     overflow,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [TS_W-1:0]   ts;
    logic              err;
  } rec_t;

  typedef enum logic {S_INIT, S_RUN} state_e;

  state_e             state_q, state_d;
  logic [DATA_W-1:0]  prev_q;
  logic [TS_W-1:0]    ts_q;
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0]   level_q, level_d;
  logic               overflow_q, overflow_d;
  rec_t               last_q;
  rec_t               mem_q [DEPTH];

  logic               evt;
  logic               step_err;
  logic               full;
  logic               pop;
  logic               push;
  rec_t               head;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_INIT;
    else        state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_INIT:  state_d = S_RUN;
      S_RUN:   state_d = S_RUN;
      default: state_d = S_INIT;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  // The INIT edge only seeds prev, so a non-zero din right after reset
  // release never produces a record.
  always_comb begin
    evt = 1'b0;
    if (state_q == S_RUN && din != prev_q) evt = 1'b1;
  end

  assign step_err = (din != DATA_W'(prev_q + 1'b1));

  // ---------------- datapath ----------------
  assign full = (level_q == LVL_W'(DEPTH));
  assign pop  = (level_q != '0) && rec.out_ready;
  // When full, a simultaneous pop frees the slot the new record lands in.
  assign push = evt && (!full || pop);

  always_comb begin
    level_d = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_comb begin
    overflow_d = overflow_q;
    if (evt && !push) overflow_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts_q       <= '0;
      prev_q     <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
      last_q     <= '0;
    end else begin
      ts_q       <= ts_q + 1'b1;
      prev_q     <= din;
      level_q    <= level_d;
      overflow_q <= overflow_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
        last_q   <= mem_q[rd_ptr_q];
      end
    end
  end

  // Storage needs no reset: occupancy is tracked by the pointers/level.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= '{data: din, ts: ts_q, err: step_err};
  end

  // Head falls through from storage while non-empty; when empty the last
  // popped record is held so the outputs stay stable.
  assign head = (level_q != '0) ? mem_q[rd_ptr_q] : last_q;

  assign rec.out_valid    = (level_q != '0);
  assign rec.out_data     = head.data;
  assign rec.out_ts       = head.ts;
  assign rec.out_step_err = head.err;
  assign overflow         = overflow_q;
  assign level            = level_q;

endmodule

// File: tb/tb_y_capture.sv
module tb_y_capture;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] din;
  logic       overflow;
  logic [2:0] level;
  logic [7:0] ts_m;
  logic [7:0] t;
  logic [7:0] tsq [$];
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  y_capture_if #(.DATA_W(4), .TS_W(8)) bus ();

  y_capture #(.DATA_W(4), .TS_W(8), .DEPTH(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .din      (din),
    .rec      (bus),
    .overflow (overflow),
    .level    (level)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock; the bench timestamp model advances on every edge out of reset.
  task automatic tick();
    @(posedge clk);
    if (rst_n) ts_m = ts_m + 8'd1;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n         = 1'b0;
    din           = 4'd0;
    bus.out_ready = 1'b0;
    ts_m          = 8'd0;

    // ---- reset state ----
    tick();
    chk("rst_valid",    32'(bus.out_valid),    32'd0);
    chk("rst_data",     32'(bus.out_data),     32'd0);
    chk("rst_ts",       32'(bus.out_ts),       32'd0);
    chk("rst_err",      32'(bus.out_step_err), 32'd0);
    chk("rst_overflow", 32'(overflow),         32'd0);
    chk("rst_level",    32'(level),            32'd0);
    tick();
    rst_n = 1'b1;
    tick();  // INIT edge
    chk("init_novalid", 32'(bus.out_valid), 32'd0);

    // ---- 1: upstream counter 1..13, consumer always ready ----
    bus.out_ready = 1'b1;
    for (int unsigned v = 1; v <= 13; v++) begin
      din = 4'(v);
      t   = ts_m;
      tick();
      chk("t1_valid", 32'(bus.out_valid),    32'd1);
      chk("t1_data",  32'(bus.out_data),     32'(v));
      chk("t1_ts",    32'(bus.out_ts),       32'(t));
      chk("t1_err",   32'(bus.out_step_err), 32'd0);
      tick();
      chk("t1_popped", 32'(bus.out_valid), 32'd0);
    end

    // ---- 2: hold din until ts reaches 252, then 14,15,0,1 across ts wrap ----
    while (ts_m != 8'd252) begin
      tick();
      chk("t2_idle", 32'(bus.out_valid), 32'd0);
    end
    for (int unsigned k = 0; k < 4; k++) begin
      din = 4'(14 + k);  // 14,15,0,1
      t   = ts_m;        // 252,254,0,2
      tick();
      chk("t2_valid", 32'(bus.out_valid),    32'd1);
      chk("t2_data",  32'(bus.out_data),     32'(4'(14 + k)));
      chk("t2_ts",    32'(bus.out_ts),       32'(t));
      chk("t2_err",   32'(bus.out_step_err), 32'd0);
      tick();
    end

    // ---- 3: consumer stalled for 5 changes -> 4 stored, 1 dropped ----
    bus.out_ready = 1'b0;
    for (int unsigned v = 2; v <= 6; v++) begin
      din = 4'(v);
      tsq.push_back(ts_m);
      tick();
      tick();
    end
    chk("t3_level",    32'(level),         32'd4);
    chk("t3_overflow", 32'(overflow),      32'd1);
    chk("t3_valid",    32'(bus.out_valid), 32'd1);
    bus.out_ready = 1'b1;
    for (int unsigned v = 2; v <= 5; v++) begin
      chk("t3_order_data", 32'(bus.out_data), 32'(v));
      chk("t3_order_ts",   32'(bus.out_ts),   32'(tsq.pop_front()));
      tick();
    end
    tsq.delete();
    chk("t3_empty",        32'(bus.out_valid), 32'd0);
    chk("t3_level0",       32'(level),         32'd0);
    chk("t3_overflow_stk", 32'(overflow),      32'd1);

    // ---- 4: jumps 6->3 and 3->7 flag step errors; held din adds nothing ----
    din = 4'd3;
    tick();
    chk("t4_data3", 32'(bus.out_data),     32'd3);
    chk("t4_err3",  32'(bus.out_step_err), 32'd1);
    tick();
    din = 4'd7;
    tick();
    chk("t4_valid7", 32'(bus.out_valid),    32'd1);
    chk("t4_data7",  32'(bus.out_data),     32'd7);
    chk("t4_err7",   32'(bus.out_step_err), 32'd1);
    for (int unsigned k = 0; k < 4; k++) begin
      tick();
      chk("t4_hold", 32'(bus.out_valid), 32'd0);
    end

    // ---- 6: reset with 3 records queued ----
    bus.out_ready = 1'b0;
    for (int unsigned v = 8; v <= 10; v++) begin
      din = 4'(v);
      tick();
      tick();
    end
    chk("t6_level3", 32'(level),         32'd3);
    chk("t6_head8",  32'(bus.out_data),  32'd8);
    rst_n = 1'b0;
    ts_m  = 8'd0;
    #1;
    chk("t6_rst_valid",    32'(bus.out_valid), 32'd0);
    chk("t6_rst_level",    32'(level),         32'd0);
    chk("t6_rst_overflow", 32'(overflow),      32'd0);
    chk("t6_rst_data",     32'(bus.out_data),  32'd0);
    chk("t6_rst_ts",       32'(bus.out_ts),    32'd0);
    din = 4'd5;
    tick();
    rst_n = 1'b1;
    tick();  // INIT edge with din=5: no record
    chk("t6_init_novalid", 32'(bus.out_valid), 32'd0);
    tick();
    chk("t6_init_novalid2", 32'(bus.out_valid), 32'd0);
    din = 4'd6;
    t   = ts_m;  // 2: timestamp restarted from 0
    tick();
    chk("t6_data6", 32'(bus.out_data),     32'd6);
    chk("t6_ts6",   32'(bus.out_ts),       32'(t));
    chk("t6_err6",  32'(bus.out_step_err), 32'd0);

    // ---- 5: full FIFO, push and pop on the same edge ----
    for (int unsigned v = 7; v <= 9; v++) begin
      din = 4'(v);
      tick();
      tick();
    end
    chk("t5_full",     32'(level),    32'd4);
    chk("t5_ovf_pre",  32'(overflow), 32'd0);
    din           = 4'd10;
    bus.out_ready = 1'b1;
    tick();
    chk("t5_level",    32'(level),        32'd4);
    chk("t5_ovf",      32'(overflow),     32'd0);
    for (int unsigned v = 7; v <= 10; v++) begin
      chk("t5_order", 32'(bus.out_data), 32'(v));
      tick();
    end
    chk("t5_empty",     32'(bus.out_valid), 32'd0);
    chk("t5_level0",    32'(level),         32'd0);
    chk("t5_hold_last", 32'(bus.out_data),  32'd10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
